mux_scan_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 4:1 select mux (Mux_4).
- Drives the mux select through channels 0..3.
- Waits a programmable settle time per channel, then samples the single-bit mux output back into a 4-bit snapshot.
- Publishes each completed snapshot atomically, with a done pulse.
- Supports single-shot and continuous scanning, plus abort.

---
 rtl/mux_scan_pkg.sv | 25 ++
 rtl/mux_scan_ctrl_if.sv | 42 ++++
 rtl/scan_dwell_cnt.sv | 30 +++
 rtl/mux_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-channel mux scan sequencer.
// Optional change detection is enabled with `define MUX_SCAN_CHANGE_DET_EN.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_t;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [NUM_CH-1:0] snap_t;

  localparam sel_t LAST_CH = sel_t'(NUM_CH - 1);

  // Every non-IDLE state belongs to an in-flight scan.
  function automatic logic state_is_busy(input scan_state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Host-side bus of the mux scan sequencer; the master modport is the sequencer.
// The changed output exists only when MUX_SCAN_CHANGE_DET_EN is defined.
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  // start is a level request, accepted only while IDLE (no queueing);
  // completion is a one-cycle done pulse that coincides with the result update.
  logic        start;
  logic        cont;
  logic        abort;
  logic        y_in;
  sel_t        sel;
  logic        busy;
  logic        done;
  snap_t       result;
  logic        valid;
  scan_state_t state_dbg;
`ifdef MUX_SCAN_CHANGE_DET_EN
  logic        changed;
`endif

`ifdef MUX_SCAN_CHANGE_DET_EN
  modport master (
    input  start, cont, abort, y_in,
    output sel, busy, done, result, valid, state_dbg, changed
  );
  modport slave (
    output start, cont, abort, y_in,
    input  sel, busy, done, result, valid, state_dbg, changed
  );
`else
  modport master (
    input  start, cont, abort, y_in,
    output sel, busy, done, result, valid, state_dbg
  );
  modport slave (
    output start, cont, abort, y_in,
    input  sel, busy, done, result, valid, state_dbg
  );
`endif

endinterface

// File: rtl/scan_dwell_cnt.sv
// Settle-time counter: term flags the last of DWELL cycles on the current channel.
module scan_dwell_cnt #(
  parameter int CNT_W = 8,
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;

  // clr wins over en so a channel always starts its dwell from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign term = (cnt_q == TERM_VAL);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequencer driving a 4:1 mux select, sampling each channel after DWELL settle
// cycles and publishing 4-bit snapshots atomically. Optional: MUX_SCAN_CHANGE_DET_EN.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  mux_scan_ctrl_if.master bus
);

  scan_state_t state_q, state_nx;
  sel_t        sel_q, sel_nx;
  snap_t       shadow_q, shadow_nx;
  snap_t       result_q, result_nx;
  logic        cont_q, cont_nx;
  logic        done_q, done_nx;
  logic        valid_q, valid_nx;
  logic        cnt_clr, cnt_en, cnt_term;
`ifdef MUX_SCAN_CHANGE_DET_EN
  logic        changed_q, changed_nx;
`endif

  scan_dwell_cnt #(
    .CNT_W (CNT_W),
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (cnt_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state_q;
    sel_nx     = sel_q;
    shadow_nx  = shadow_q;
    result_nx  = result_q;
    cont_nx    = cont_q;
    done_nx    = 1'b0;
    valid_nx   = valid_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
`ifdef MUX_SCAN_CHANGE_DET_EN
    changed_nx = 1'b0;
`endif

    // Abort drops the partial snapshot; the published result/valid are untouched.
    if (bus.abort && state_q != ST_IDLE) begin
      state_nx  = ST_IDLE;
      sel_nx    = '0;
      shadow_nx = '0;
      cnt_clr   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          sel_nx  = '0;
          cnt_clr = 1'b1;
          if (bus.start && !bus.abort) begin
            state_nx = ST_SETTLE;
            cont_nx  = bus.cont;
          end
        end

        ST_SETTLE: begin
          cnt_en = 1'b1;
          if (cnt_term) begin
            state_nx = ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          shadow_nx[sel_q] = bus.y_in;
          cnt_clr          = 1'b1;
          if (sel_q == LAST_CH) begin
            state_nx = ST_DONE;
          end else begin
            sel_nx   = sel_q + sel_t'(1);
            state_nx = ST_SETTLE;
          end
        end

        ST_DONE: begin
          result_nx  = shadow_q;
          done_nx    = 1'b1;
          valid_nx   = 1'b1;
          sel_nx     = '0;
          cnt_clr    = 1'b1;
`ifdef MUX_SCAN_CHANGE_DET_EN
          changed_nx = (shadow_q != result_q);
`endif
          // Continuing needs both the latched mode and the live input.
          if (cont_q && bus.cont) begin
            state_nx = ST_SETTLE;
          end else begin
            state_nx = ST_IDLE;
          end
        end

        default: begin
          state_nx = ST_IDLE;
          sel_nx   = '0;
          cnt_clr  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      shadow_q  <= '0;
      result_q  <= '0;
      cont_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      sel_q     <= sel_nx;
      shadow_q  <= shadow_nx;
      result_q  <= result_nx;
      cont_q    <= cont_nx;
      done_q    <= done_nx;
      valid_q   <= valid_nx;
    end
  end

`ifdef MUX_SCAN_CHANGE_DET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_nx;
    end
  end

  assign bus.changed = changed_q;
`endif

  assign bus.sel       = sel_q;
  assign bus.busy      = state_is_busy(state_q);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.valid     = valid_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: scoreboard of expected snapshots and done cycles.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  localparam int DWELL    = 4;
  localparam int SCAN_LAT = NUM_CH * (DWELL + 1) + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] k_pat;

  int total     = 0;
  int bad       = 0;
  int cyc       = 0;
  int done_cnt  = 0;
  int n_pushed  = 0;

  logic [3:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [3:0] prev_res;

  mux_scan_ctrl_if bus_if ();

  mux_scan_ctrl #(
    .DWELL (DWELL),
    .CNT_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Mux_4 model: channel pattern K selected by the DUT.
  assign bus_if.y_in = k_pat[bus_if.sel];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    logic [3:0] e;
    int         c;
    if (!rst_n) begin
      prev_res = 4'd0;
    end else if (bus_if.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("result", 32'(bus_if.result), 32'(e));
        check("done_latency", 32'(cyc), 32'(c));
        check("valid_at_done", 32'(bus_if.valid), 32'd1);
`ifdef MUX_SCAN_CHANGE_DET_EN
        check("changed", 32'(bus_if.changed), 32'(e != prev_res));
`endif
        prev_res = e;
      end
    end
  end

  task automatic pulse_start(input logic [3:0] k, input logic c, input bit expect_done);
    @(posedge clk); #1;
    k_pat         = k;
    bus_if.cont   = c;
    bus_if.start  = 1'b1;
    @(posedge clk); #1;
    bus_if.start  = 1'b0;
    if (expect_done) begin
      exp_q.push_back(k);
      exp_cyc_q.push_back(cyc + SCAN_LAT);
      n_pushed++;
    end
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.done && n < max_cyc);
    if (!bus_if.done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.cont  = 1'b0;
    bus_if.abort = 1'b0;
    k_pat        = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_sel", 32'(bus_if.sel), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    check("rst_result", 32'(bus_if.result), 32'd0);
    check("rst_valid", 32'(bus_if.valid), 32'd0);
    check("rst_state", 32'(bus_if.state_dbg), 32'(ST_IDLE));
    #2 rst_n = 1'b1;

    // Single scan: each channel held DWELL+1 cycles, done after SCAN_LAT.
    pulse_start(4'b1010, 1'b0, 1'b1);
    for (int i = 0; i < NUM_CH * (DWELL + 1); i++) begin
      @(negedge clk);
      check("sel_seq", 32'(bus_if.sel), 32'(i / (DWELL + 1)));
      check("busy_scan", 32'(bus_if.busy), 32'd1);
    end
    wait_done(SCAN_LAT + 5);
    check("valid_set", 32'(bus_if.valid), 32'd1);
    @(negedge clk);
    check("idle_after", 32'(bus_if.state_dbg), 32'(ST_IDLE));
    check("sel_idle", 32'(bus_if.sel), 32'd0);
    check("done_one_cycle", 32'(bus_if.done), 32'd0);

    // Continuous: second scan starts without an IDLE gap.
    pulse_start(4'b0011, 1'b1, 1'b1);
    wait_done(SCAN_LAT + 5);
    check("cont_no_gap", 32'(bus_if.state_dbg), 32'(ST_SETTLE));
    k_pat       = 4'b1100;
    exp_q.push_back(4'b1100);
    exp_cyc_q.push_back(cyc + SCAN_LAT);
    n_pushed++;
    bus_if.cont = 1'b0;
    wait_done(SCAN_LAT + 5);
    @(negedge clk);
    check("cont_stop_idle", 32'(bus_if.state_dbg), 32'(ST_IDLE));

    // Abort during SETTLE of channel 2 after a published 0101.
    pulse_start(4'b0101, 1'b0, 1'b1);
    wait_done(SCAN_LAT + 5);
    pulse_start(4'b1111, 1'b0, 1'b0);
    repeat (2 * (DWELL + 1) + 1) @(negedge clk);
    check("pre_abort_state", 32'(bus_if.state_dbg), 32'(ST_SETTLE));
    check("pre_abort_sel", 32'(bus_if.sel), 32'd2);
    bus_if.abort = 1'b1;
    @(posedge clk); #1;
    bus_if.abort = 1'b0;
    @(negedge clk);
    check("abort_state", 32'(bus_if.state_dbg), 32'(ST_IDLE));
    check("abort_sel", 32'(bus_if.sel), 32'd0);
    check("abort_done", 32'(bus_if.done), 32'd0);
    check("abort_result", 32'(bus_if.result), 32'(4'b0101));
    check("abort_valid", 32'(bus_if.valid), 32'd1);
    repeat (SCAN_LAT + 4) @(negedge clk);
    check("abort_result_hold", 32'(bus_if.result), 32'(4'b0101));

    // start while busy is ignored; start+abort in IDLE stays IDLE.
    pulse_start(4'b1001, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_done(SCAN_LAT + 5);
    repeat (2) @(negedge clk);
    check("busy_start_idle", 32'(bus_if.state_dbg), 32'(ST_IDLE));
    bus_if.start = 1'b1;
    bus_if.abort = 1'b1;
    @(negedge clk);
    check("start_abort_idle", 32'(bus_if.state_dbg), 32'(ST_IDLE));
    check("start_abort_busy", 32'(bus_if.busy), 32'd0);
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    repeat (SCAN_LAT + 4) @(negedge clk);

    // Async reset mid-SAMPLE, between edges, then a fresh scan.
    pulse_start(4'b0110, 1'b0, 1'b0);
    repeat (2 * (DWELL + 1)) @(negedge clk);
    check("pre_rst_state", 32'(bus_if.state_dbg), 32'(ST_SAMPLE));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sel", 32'(bus_if.sel), 32'd0);
    check("mid_rst_busy", 32'(bus_if.busy), 32'd0);
    check("mid_rst_done", 32'(bus_if.done), 32'd0);
    check("mid_rst_result", 32'(bus_if.result), 32'd0);
    check("mid_rst_valid", 32'(bus_if.valid), 32'd0);
    @(negedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    pulse_start(4'b0110, 1'b0, 1'b1);
    wait_done(SCAN_LAT + 5);

    // Change-detect sequence from a clean reset: 0110, 0110, 0111.
    do_reset();
    pulse_start(4'b0110, 1'b0, 1'b1);
    wait_done(SCAN_LAT + 5);
    pulse_start(4'b0110, 1'b0, 1'b1);
    wait_done(SCAN_LAT + 5);
    pulse_start(4'b0111, 1'b0, 1'b1);
    wait_done(SCAN_LAT + 5);
    repeat (3) @(negedge clk);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'(n_pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
